ifft_twiddle_sequencer: RTL

Frame and twiddle-address controller for the 128-point radix-2 SDF IFFT. It tracks frame boundaries on the input stream, keeps one sample counter per SDF stage, and drives each stage's twiddle ROM address and multiply/bypass select. After the last sample of a frame it commands a zero-injection drain so the pipeline flushes. It sits beside the SDF datapath and feeds the shared-format twiddle ROMs, which have a combinational read and a 64-entry depth.

---
 rtl/ifft_twiddle_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ifft_twiddle_sequencer.sv
// ifft_twiddle_sequencer: frame and twiddle-address controller for a radix-2 SDF IFFT.
// Tracks frame boundaries on the input stream, keeps one sample counter per SDF stage,
// drives each stage's twiddle ROM address / multiply-bypass select, and commands a
// zero-injection drain after the last sample of a frame.
// Optional feature: define SYNC_CHECK_EN to resync on a misaligned in_first while running.
module ifft_twiddle_sequencer #(
  parameter int unsigned NFFT         = 128,
  parameter int unsigned STAGES       = $clog2(NFFT),
  parameter int unsigned AW           = $clog2(NFFT / 2),
  parameter int unsigned DRAIN_CYCLES = 127
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic [STAGES-1:0]    stage_valid,
  output logic [STAGES*AW-1:0] tw_addr,
  output logic [STAGES-1:0]    tw_sel,
  output logic                 drain,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 sync_err
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [STAGES-1:0] frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic              start;
  logic              resync;
  logic              drain_last;

  logic [STAGES-1:0] stage_cnt_q [STAGES];
  logic [AW-1:0]     addr_q      [STAGES];
  logic [AW-1:0]     addr_nxt    [STAGES];

  assign start      = in_valid & in_first;
  assign drain_last = (drain_cnt_q == DW'(DRAIN_CYCLES - 1));

`ifdef SYNC_CHECK_EN
  // A new frame marker mid-frame restarts the frame and realigns every stage counter.
  assign resync = (state_q == StRun) && start && (frame_cnt_q != '0);
`else
  assign resync = 1'b0;
`endif

  // State and frame/drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      frame_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StRun;
          frame_cnt_d = STAGES'(1);
        end
      end
      StRun: begin
        if (resync) begin
          frame_cnt_d = STAGES'(1);
        end else if (in_valid) begin
          frame_cnt_d = frame_cnt_q + STAGES'(1);
          // Last sample of the frame: frame counter is at NFFT-1 before the increment
          if (frame_cnt_q == '1) begin
            state_d     = StDrain;
            drain_cnt_d = '0;
          end
        end
      end
      StDrain: begin
        if (start) begin
          state_d     = StRun;
          frame_cnt_d = STAGES'(1);
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
          if (drain_last) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy       = (state_q != StIdle);
    drain      = (state_q == StDrain) && !start;
    frame_done = (state_q == StDrain) && (start || drain_last);
    sync_err   = resync;
  end

  // Twiddle address per stage: low counter bits below the half-segment bit, scaled by 2^s
  always_comb begin
    for (int s = 0; s < int'(STAGES); s++) begin
      addr_nxt[s] = AW'(stage_cnt_q[s] << s);
    end
  end

  // Stage counters and registered twiddle address/select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_sel <= '0;
      for (int s = 0; s < int'(STAGES); s++) begin
        stage_cnt_q[s] <= '0;
        addr_q[s]      <= '0;
      end
    end else begin
      for (int s = 0; s < int'(STAGES); s++) begin
        if (stage_valid[s]) begin
          addr_q[s] <= addr_nxt[s];
          tw_sel[s] <= stage_cnt_q[s][STAGES-1-s];
        end
        if (resync) begin
          stage_cnt_q[s] <= '0;
        end else if (stage_valid[s]) begin
          stage_cnt_q[s] <= stage_cnt_q[s] + STAGES'(1);
        end
      end
    end
  end

  // Pack per-stage addresses onto the flat output bus
  always_comb begin
    tw_addr = '0;
    for (int s = 0; s < int'(STAGES); s++) begin
      tw_addr[s*AW +: AW] = addr_q[s];
    end
  end

endmodule
